// File: rtl/packet_storer_pkg.sv
// Shared definitions for the packet store path.
// Packet geometry (160-bit packets split into five 32-bit memory words, MSB
// word first), the store FSM state type and a word-select helper.
package packet_storer_pkg;

    localparam int unsigned PACKET_WIDTH = 160;
    localparam int unsigned WORD_BITS    = 32;
    localparam int unsigned WORD_COUNT   = PACKET_WIDTH / WORD_BITS;
    localparam int unsigned CNT_W        = 3;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StAck
    } state_e;

    // Most significant memory word of a packet; the first one written.
    function automatic logic [WORD_BITS-1:0] top_word(input logic [PACKET_WIDTH-1:0] pkt);
        return pkt[PACKET_WIDTH-1 -: WORD_BITS];
    endfunction

endpackage

// File: rtl/packet_storer.sv
// packet_storer: writes one packet to memory as WORD_COUNT consecutive 32-bit
// words starting at PCADDR + offset, most significant word first, then raises
// an acknowledge carrying the offset.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   PCADDR                   packet-area base address (static while out of reset)
//   RECEIVE_ST_*             store request channel (valid/ready): offset + packet
//   MEM_SEND_*               memory write command: address, data, valids, ready
//   SEND_ACK_*               store-complete channel (valid/ready) with offset
// All outputs are registered.
module packet_storer
    import packet_storer_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [31:0]             PCADDR,
    input  logic                    RECEIVE_ST_VALID,
    input  logic [15:0]             RECEIVE_ST_ADDR,
    input  logic [PACKET_WIDTH-1:0] RECEIVE_ST_DATA,
    output logic                    RECEIVE_ST_READY,
    output logic                    MEM_SEND_ADDR_VALID,
    output logic [31:0]             MEM_SEND_ADDR,
    output logic                    MEM_SEND_DATA_VALID,
    output logic [31:0]             MEM_SEND_DATA,
    input  logic                    MEM_SEND_READY,
    output logic                    SEND_ACK_VALID,
    output logic [15:0]             SEND_ACK_ADDR,
    input  logic                    SEND_ACK_READY
);

    localparam logic [CNT_W-1:0] LastWord = CNT_W'(WORD_COUNT - 1);

    state_e                  state_q, state_d;
    logic                    rdy_q, rdy_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    // Remaining words, left-aligned: the next word to send is always the top slice.
    logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             off_q, off_d;
    logic                    ack_valid_q, ack_valid_d;
    logic [15:0]             ack_addr_q, ack_addr_d;

    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        wr_valid_d  = wr_valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pkt_d       = pkt_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        ack_valid_d = ack_valid_q;
        ack_addr_d  = ack_addr_q;

        unique case (state_q)
            StIdle: begin
                // Ready comes up one edge after reset release and stays up until accept.
                rdy_d = 1'b1;
                if (RECEIVE_ST_VALID && rdy_q) begin
                    rdy_d      = 1'b0;
                    wr_valid_d = 1'b1;
                    // Offset is used as-is; low bits are not forced to word alignment.
                    addr_d     = PCADDR + {16'h0000, RECEIVE_ST_ADDR};
                    data_d     = top_word(RECEIVE_ST_DATA);
                    pkt_d      = RECEIVE_ST_DATA << WORD_BITS;
                    cnt_d      = '0;
                    off_d      = RECEIVE_ST_ADDR;
                    state_d    = StWrite;
                end
            end
            StWrite: begin
                if (MEM_SEND_READY) begin
                    if (cnt_q == LastWord) begin
                        wr_valid_d  = 1'b0;
                        ack_valid_d = 1'b1;
                        ack_addr_d  = off_q;
                        state_d     = StAck;
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        addr_d = addr_q + 32'd4;
                        data_d = top_word(pkt_q);
                        pkt_d  = pkt_q << WORD_BITS;
                    end
                end
            end
            StAck: begin
                if (SEND_ACK_READY) begin
                    ack_valid_d = 1'b0;
                    rdy_d       = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b0;
            wr_valid_q  <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            pkt_q       <= '0;
            cnt_q       <= '0;
            off_q       <= '0;
            ack_valid_q <= 1'b0;
            ack_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            wr_valid_q  <= wr_valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pkt_q       <= pkt_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            ack_valid_q <= ack_valid_d;
            ack_addr_q  <= ack_addr_d;
        end
    end

    assign RECEIVE_ST_READY    = rdy_q;
    // One valid flop drives both: every command is a write.
    assign MEM_SEND_ADDR_VALID = wr_valid_q;
    assign MEM_SEND_DATA_VALID = wr_valid_q;
    assign MEM_SEND_ADDR       = addr_q;
    assign MEM_SEND_DATA       = data_q;
    assign SEND_ACK_VALID      = ack_valid_q;
    assign SEND_ACK_ADDR       = ack_addr_q;

endmodule

// File: tb/tb_packet_storer.sv
// Self-checking bench for packet_storer: reset checks, a table of directed
// stores, cycle-exact basic store, backpressure, ack stall, reset mid-store and
// randomized traffic scored against a queue-based memory model.
module tb_packet_storer;
    import packet_storer_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic [31:0]             pcaddr;
    logic                    st_valid;
    logic [15:0]             st_addr;
    logic [PACKET_WIDTH-1:0] st_data;
    logic                    st_ready;
    logic                    mem_avalid;
    logic [31:0]             mem_addr;
    logic                    mem_dvalid;
    logic [31:0]             mem_data;
    logic                    mem_ready;
    logic                    ack_valid;
    logic [15:0]             ack_addr;
    logic                    ack_rdy;

    packet_storer dut (
        .CLK                 (clk),
        .RST                 (rst_n),
        .PCADDR              (pcaddr),
        .RECEIVE_ST_VALID    (st_valid),
        .RECEIVE_ST_ADDR     (st_addr),
        .RECEIVE_ST_DATA     (st_data),
        .RECEIVE_ST_READY    (st_ready),
        .MEM_SEND_ADDR_VALID (mem_avalid),
        .MEM_SEND_ADDR       (mem_addr),
        .MEM_SEND_DATA_VALID (mem_dvalid),
        .MEM_SEND_DATA       (mem_data),
        .MEM_SEND_READY      (mem_ready),
        .SEND_ACK_VALID      (ack_valid),
        .SEND_ACK_ADDR       (ack_addr),
        .SEND_ACK_READY      (ack_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [15:0] exp_ack_q[$];
    logic [31:0] wr_log[$];
    logic [31:0] wr_dlog[$];
    logic [15:0] ack_log[$];
    int          req_count = 0;
    int          wr_count  = 0;
    int          ack_count = 0;
    int          cyc = 0;
    int          last_req_cyc = 0;
    int          last_ack_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;

    // Handshakes are observed at the falling edge before the rising edge that takes them.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            exp_ack_q.delete();
            prev_stall = 1'b0;
        end else begin
            cyc++;
            check32("valid_pair", 32'(mem_dvalid), 32'(mem_avalid));
            if (prev_stall) begin
                check32("stall_valid", 32'(mem_avalid), 32'd1);
                check32("stall_addr", mem_addr, prev_addr);
                check32("stall_data", mem_data, prev_data);
            end
            prev_stall = mem_avalid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            if (st_valid && st_ready) begin
                logic [31:0]             base;
                logic [PACKET_WIDTH-1:0] sh;
                base = pcaddr + {16'h0000, st_addr};
                for (int i = 0; i < int'(WORD_COUNT); i++) begin
                    sh = st_data >> (32 * (int'(WORD_COUNT) - 1 - i));
                    exp_addr_q.push_back(base + 32'(4 * i));
                    exp_data_q.push_back(sh[31:0]);
                end
                exp_ack_q.push_back(st_addr);
                req_count++;
                last_req_cyc = cyc;
            end
            if (mem_avalid && mem_ready) begin
                wr_count++;
                wr_log.push_back(mem_addr);
                wr_dlog.push_back(mem_data);
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got addr %08h expected no write", mem_addr);
                end else begin
                    check32("wr_addr", mem_addr, exp_addr_q.pop_front());
                    check32("wr_data", mem_data, exp_data_q.pop_front());
                end
            end
            if (ack_valid && ack_rdy) begin
                ack_count++;
                ack_log.push_back(ack_addr);
                last_ack_cyc = cyc;
                if (exp_ack_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ack: got %04h expected no ack", ack_addr);
                end else begin
                    check32("ack_addr", 32'(ack_addr), 32'(exp_ack_q.pop_front()));
                    check32("ack_order", 32'(exp_addr_q.size()), 32'd0);
                end
            end
        end
    end

    // ---------------- memory / ack ready drivers ----------------
    int mem_mode = 0;  // 0 always ready, 1 random, 2 three stall cycles per word
    int ack_mode = 0;  // 0 manual, 1 random
    int stall_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mem_mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (mem_ready) begin
                        mem_ready = 1'b0;
                        stall_cnt = 0;
                    end
                    if (mem_avalid) begin
                        stall_cnt++;
                        if (stall_cnt == 4) mem_ready = 1'b1;
                    end
                end
            endcase
            if (ack_mode == 1) ack_rdy = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- tasks ----------------
    task automatic apply_reset(input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        pcaddr   = pc;
        st_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Returns at 1ns after the rising edge that accepted the request.
    task automatic send_req(input logic [15:0] off, input logic [PACKET_WIDTH-1:0] pkt);
        int start;
        bit done;
        @(posedge clk);
        #1;
        st_valid = 1'b1;
        st_addr  = off;
        st_data  = pkt;
        start    = req_count;
        done     = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            if (req_count != start) done = 1'b1;
        end
        #1;
        st_valid = 1'b0;
        st_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        check32("req_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_acks(input int target);
        bit done;
        done = (ack_count >= target);
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk);
            if (ack_count >= target) done = 1'b1;
        end
        #1;
        check32("ack_arrived", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [31:0]             pc;
        logic [15:0]             off;
        logic [PACKET_WIDTH-1:0] pkt;
        logic [31:0]             a0;
        logic [31:0]             a4;
        logic [31:0]             d0;
        logic [31:0]             d4;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [PACKET_WIDTH-1:0] pkt_basic;
        int                      ac;
        int                      wc;
        bit                      found;
        logic [15:0]             roff;

        vecs[0] = '{32'h2000_0000, 16'h0010,
                    160'h11111111_22222222_33333333_44444444_55555555,
                    32'h2000_0010, 32'h2000_0020, 32'h1111_1111, 32'h5555_5555};
        vecs[1] = '{32'hFFFF_FFF8, 16'h0000,
                    160'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_0BADF00D,
                    32'hFFFF_FFF8, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0BAD_F00D};
        vecs[2] = '{32'h0000_1000, 16'hFFFC,
                    160'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000_13579BDF,
                    32'h0001_0FFC, 32'h0001_100C, 32'hA5A5_A5A5, 32'h1357_9BDF};
        vecs[3] = '{32'h8000_0000, 16'h0003,
                    160'h00000001_00000002_00000003_00000004_00000005,
                    32'h8000_0003, 32'h8000_0013, 32'h0000_0001, 32'h0000_0005};
        pkt_basic = 160'h11111111_22222222_33333333_44444444_55555555;

        // Reset with every input asserted.
        rst_n     = 1'b0;
        pcaddr    = 32'h1234_5678;
        st_valid  = 1'b1;
        st_addr   = 16'hFFFF;
        st_data   = '1;
        mem_ready = 1'b1;
        ack_rdy   = 1'b1;
        @(negedge clk);
        check32("rst_st_ready", 32'(st_ready), 32'd0);
        check32("rst_avalid", 32'(mem_avalid), 32'd0);
        check32("rst_dvalid", 32'(mem_dvalid), 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_mem_data", mem_data, 32'd0);
        check32("rst_ack_valid", 32'(ack_valid), 32'd0);
        check32("rst_ack_addr", 32'(ack_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        st_valid = 1'b0;
        @(negedge clk);
        check32("ready_before_edge", 32'(st_ready), 32'd0);
        @(negedge clk);
        check32("ready_after_edge", 32'(st_ready), 32'd1);

        // Cycle-exact basic store, memory always ready.
        apply_reset(32'h2000_0000);
        send_req(16'h0010, pkt_basic);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32("basic_avalid", 32'(mem_avalid), 32'd1);
            check32("basic_busy", 32'(st_ready), 32'd0);
            check32("basic_addr", mem_addr, 32'h2000_0010 + 32'(4 * k));
            check32("basic_data", mem_data, 32'h1111_1111 * 32'(k + 1));
        end
        @(negedge clk);
        check32("basic_avalid_drop", 32'(mem_avalid), 32'd0);
        check32("basic_ack_valid", 32'(ack_valid), 32'd1);
        check32("basic_ack_addr", 32'(ack_addr), 32'h0010);
        @(negedge clk);
        check32("basic_ack_clear", 32'(ack_valid), 32'd0);
        check32("basic_ready_back", 32'(st_ready), 32'd1);

        // Table of directed stores.
        for (int v = 0; v < 4; v++) begin
            apply_reset(vecs[v].pc);
            wr_log.delete();
            wr_dlog.delete();
            ack_log.delete();
            ac = ack_count;
            send_req(vecs[v].off, vecs[v].pkt);
            wait_acks(ac + 1);
            check32("vec_nwords", 32'(wr_log.size()), 32'd5);
            if (wr_log.size() == 5) begin
                check32("vec_a0", wr_log[0], vecs[v].a0);
                check32("vec_a4", wr_log[4], vecs[v].a4);
                check32("vec_d0", wr_dlog[0], vecs[v].d0);
                check32("vec_d4", wr_dlog[4], vecs[v].d4);
            end
            if (ack_log.size() == 1) check32("vec_ack", 32'(ack_log[0]), 32'(vecs[v].off));
            else check32("vec_nacks", 32'(ack_log.size()), 32'd1);
        end

        // Backpressure: three stall cycles before every word.
        apply_reset(32'h2000_0000);
        mem_mode = 2;
        wr_log.delete();
        ac = ack_count;
        send_req(16'h0010, pkt_basic);
        wait_acks(ac + 1);
        check32("bp_nwords", 32'(wr_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < wr_log.size(); k++) begin
            check32("bp_addr", wr_log[k], 32'h2000_0010 + 32'(4 * k));
        end
        mem_mode = 0;

        // Ack stall with a second request pending.
        apply_reset(32'h0400_0000);
        ack_rdy = 1'b0;
        ac = ack_count;
        send_req(16'h0100, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        st_valid = 1'b1;
        st_addr  = 16'h0200;
        st_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (ack_valid) found = 1'b1;
        end
        check32("stall_ack_seen", 32'(found), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check32("stall_ack_held", 32'(ack_valid), 32'd1);
            check32("stall_not_ready", 32'(st_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        ack_rdy = 1'b1;
        wc = req_count;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            if (req_count != wc) found = 1'b1;
        end
        #1;
        st_valid = 1'b0;
        check32("stall_second_accepted", 32'(found), 32'd1);
        check32("stall_req_after_ack", 32'(last_req_cyc), 32'(last_ack_cyc + 1));
        wait_acks(ac + 2);

        // Reset while word 3 is pending.
        apply_reset(32'h3000_0000);
        wc = wr_count;
        send_req(16'h0040, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            if (wr_count >= wc + 3) found = 1'b1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check32("mid_rst_seen_words", 32'(found), 32'd1);
        check32("mid_rst_avalid", 32'(mem_avalid), 32'd0);
        check32("mid_rst_dvalid", 32'(mem_dvalid), 32'd0);
        check32("mid_rst_ack", 32'(ack_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ac = ack_count;
        repeat (10) @(posedge clk);
        #1;
        check32("mid_rst_no_ack", 32'(ack_count), 32'(ac));
        check32("mid_rst_no_more_words", 32'(wr_count), 32'(wc + 3));
        wr_log.delete();
        send_req(16'h0080, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        wait_acks(ac + 1);
        check32("mid_rst_restart_n", 32'(wr_log.size()), 32'd5);
        if (wr_log.size() > 0) check32("mid_rst_restart_a0", wr_log[0], 32'h3000_0080);

        // Randomized traffic against the model.
        apply_reset($urandom());
        mem_mode = 1;
        ack_mode = 1;
        ac = ack_count;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            roff = 16'($urandom_range(0, 65535)) & 16'hFFFC;
            send_req(roff, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        end
        wait_acks(ac + 25);
        ack_mode = 0;
        mem_mode = 0;
        ack_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("sb_writes_drained", 32'(exp_addr_q.size()), 32'd0);
        check32("sb_acks_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
